// File: rtl/hour_counter_cfg.sv
// Hour stage of the digital clock: binary 0..23 hour advanced by the minute carry,
// 12h/24h BCD display one edge behind hour_bin, set mode with press-and-hold auto-repeat.
module hour_counter_cfg #(
    parameter int RESET_HOUR   = 0,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_in,
    input  logic       set_en,
    input  logic       btn_up,
    input  logic       btn_dn,
    input  logic       mode_24,
    output logic [4:0] hour_bin,
    output logic [3:0] hour_tens,
    output logic [3:0] hour_ones,
    output logic       pm,
    output logic       carry_out
);

    localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CW      = (MAX_CNT > 2) ? $clog2(MAX_CNT) : 1;
    localparam logic [CW-1:0] LAST_DELAY = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] LAST_RATE  = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          act_up, act_nx;
    logic          up_q, dn_q, hist_vld;
    logic          step_up, step_dn, held, other;
    logic [4:0]    hour_inc, hour_dec, disp;
    logic [3:0]    tens_nx, ones_nx;

    assign hour_inc = (hour_bin == 5'd23) ? 5'd0  : hour_bin + 5'd1;
    assign hour_dec = (hour_bin == 5'd0)  ? 5'd23 : hour_bin - 5'd1;
    assign held     = act_up ? btn_up : btn_dn;
    assign other    = act_up ? btn_dn : btn_up;

    // hist_vld keeps a button held through reset from looking like a fresh press
    always_comb begin
        step_up  = 1'b0;
        step_dn  = 1'b0;
        state_nx = IDLE;
        cnt_nx   = '0;
        act_nx   = act_up;
        if (set_en) begin
            case (state)
                IDLE: begin
                    if (hist_vld && btn_up && !up_q && !btn_dn) begin
                        step_up  = 1'b1;
                        state_nx = DELAY;
                        act_nx   = 1'b1;
                    end else if (hist_vld && btn_dn && !dn_q && !btn_up) begin
                        step_dn  = 1'b1;
                        state_nx = DELAY;
                        act_nx   = 1'b0;
                    end
                end
                DELAY, REPEAT: begin
                    if (held && !other) begin
                        if (cnt == ((state == DELAY) ? LAST_DELAY : LAST_RATE)) begin
                            step_up  = act_up;
                            step_dn  = !act_up;
                            state_nx = REPEAT;
                        end else begin
                            state_nx = state;
                            cnt_nx   = cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        disp = hour_bin;
        if (!mode_24) begin
            if (hour_bin >= 5'd12)
                disp = hour_bin - 5'd12;
            if (disp == 5'd0)
                disp = 5'd12;
        end
        if (disp >= 5'd20) begin
            tens_nx = 4'd2;
            ones_nx = 4'(disp - 5'd20);
        end else if (disp >= 5'd10) begin
            tens_nx = 4'd1;
            ones_nx = 4'(disp - 5'd10);
        end else begin
            tens_nx = 4'd0;
            ones_nx = disp[3:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hour_bin  <= 5'(RESET_HOUR);
            hour_tens <= 4'd0;
            hour_ones <= 4'd0;
            pm        <= 1'b0;
            carry_out <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            act_up    <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            hist_vld  <= 1'b0;
        end else begin
            up_q      <= btn_up;
            dn_q      <= btn_dn;
            hist_vld  <= 1'b1;
            state     <= state_nx;
            cnt       <= cnt_nx;
            act_up    <= act_nx;
            carry_out <= !set_en && tick_in && (hour_bin == 5'd23);
            if (!set_en) begin
                if (tick_in)
                    hour_bin <= hour_inc;
            end else if (step_up) begin
                hour_bin <= hour_inc;
            end else if (step_dn) begin
                hour_bin <= hour_dec;
            end
            hour_tens <= tens_nx;
            hour_ones <= ones_nx;
            pm        <= (hour_bin >= 5'd12);
        end
    end

endmodule

// File: tb/tb_hour_counter_cfg.sv
// Bench for hour_counter_cfg: vector table, hand-written repeat/conflict/reset sequences,
// then randomized stimulus against an elapsed-time reference model.
module tb_hour_counter_cfg;

    localparam int RH = 7;
    localparam int D  = 8;
    localparam int R  = 3;

    logic       clk = 1'b0;
    logic       reset, tick_in, set_en, btn_up, btn_dn, mode_24;
    logic [4:0] hour_bin;
    logic [3:0] hour_tens, hour_ones;
    logic       pm, carry_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hour_counter_cfg #(.RESET_HOUR(RH), .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
        .clk(clk), .reset(reset), .tick_in(tick_in), .set_en(set_en),
        .btn_up(btn_up), .btn_dn(btn_dn), .mode_24(mode_24),
        .hour_bin(hour_bin), .hour_tens(hour_tens), .hour_ones(hour_ones),
        .pm(pm), .carry_out(carry_out)
    );

    typedef struct {
        logic se, up, dn, tk, m24;
        int   hour, tens, ones, pm, carry;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic se, up, dn, tk, m24, input int h, t, o, p, c);
        vec_t r;
        r.se = se; r.up = up; r.dn = dn; r.tk = tk; r.m24 = m24;
        r.hour = h; r.tens = t; r.ones = o; r.pm = p; r.carry = c;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int h, t, o, p, c);
        tests++;
        if (hour_bin !== 5'(h) || hour_tens !== 4'(t) || hour_ones !== 4'(o) ||
            pm !== 1'(p) || carry_out !== 1'(c)) begin
            fails++;
            $display("FAIL %s: got hour=%0d tens=%0d ones=%0d pm=%0d carry=%0d, want %0d %0d %0d %0d %0d",
                     nm, hour_bin, hour_tens, hour_ones, pm, carry_out, h, t, o, p, c);
        end
    endtask

    task automatic chk_v(input string nm, input logic [31:0] act, input int exp);
        tests++;
        if (act !== 32'(exp)) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // reference model: hour arithmetic mod 24, repeat timing from cycles held since press
    int m_hour, m_tens, m_ones, m_pm, m_carry, m_act, m_el;
    logic m_pu, m_pd, m_hv;

    task automatic model_reset();
        m_hour = RH; m_tens = 0; m_ones = 0; m_pm = 0; m_carry = 0;
        m_act = 0; m_el = 0; m_pu = 0; m_pd = 0; m_hv = 0;
    endtask

    task automatic model_edge();
        int shown, step;
        logic hld, oth;
        shown  = mode_24 ? m_hour : (((m_hour % 12) == 0) ? 12 : m_hour % 12);
        m_tens = shown / 10;
        m_ones = shown % 10;
        m_pm   = (m_hour >= 12) ? 1 : 0;
        step   = 0;
        if (!set_en) begin
            m_act   = 0;
            m_carry = (tick_in && m_hour == 23) ? 1 : 0;
            if (tick_in) m_hour = (m_hour + 1) % 24;
        end else begin
            m_carry = 0;
            if (m_act != 0) begin
                hld = (m_act == 1) ? btn_up : btn_dn;
                oth = (m_act == 1) ? btn_dn : btn_up;
                if (!hld || oth) m_act = 0;
                else begin
                    m_el++;
                    if (m_el == D || (m_el > D && (m_el - D) % R == 0))
                        step = (m_act == 1) ? 1 : -1;
                end
            end else if (m_hv) begin
                if (btn_up && !m_pu && !btn_dn) begin m_act = 1; m_el = 0; step = 1; end
                else if (btn_dn && !m_pd && !btn_up) begin m_act = 2; m_el = 0; step = -1; end
            end
            m_hour = (m_hour + step + 24) % 24;
        end
        m_pu = btn_up;
        m_pd = btn_dn;
        m_hv = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int steps[5] = '{0, 8, 11, 14, 17};
        int exp, up_t, dn_t;

        reset = 1; tick_in = 0; set_en = 0; btn_up = 0; btn_dn = 0; mode_24 = 0;
        #1;
        chk("reset", RH, 0, 0, 0, 0);
        repeat (2) cyc();
        reset = 0;

        tbl.push_back(v(0,0,0,1,0,  8,0,7,0,0));
        tbl.push_back(v(0,0,0,1,0,  9,0,8,0,0));
        tbl.push_back(v(0,0,0,1,0, 10,0,9,0,0));
        tbl.push_back(v(0,0,0,1,0, 11,1,0,0,0));
        tbl.push_back(v(0,0,0,0,0, 11,1,1,0,0));
        tbl.push_back(v(0,0,0,1,0, 12,1,1,0,0));
        tbl.push_back(v(0,0,0,0,0, 12,1,2,1,0));
        tbl.push_back(v(0,0,0,1,0, 13,1,2,1,0));
        tbl.push_back(v(0,0,0,0,0, 13,0,1,1,0));
        tbl.push_back(v(0,0,0,0,1, 13,1,3,1,0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(v(0,0,0,1,1, 14 + i, (13 + i) / 10, (13 + i) % 10, 1, 0));
        tbl.push_back(v(0,0,0,1,1,  0,2,3,1,1));
        tbl.push_back(v(0,0,0,0,1,  0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,  0,1,2,0,0));
        tbl.push_back(v(1,0,1,0,0, 23,1,2,0,0));
        tbl.push_back(v(1,0,0,1,0, 23,1,1,1,0));
        tbl.push_back(v(1,0,0,1,0, 23,1,1,1,0));
        tbl.push_back(v(1,1,1,0,0, 23,1,1,1,0));
        tbl.push_back(v(1,1,1,0,0, 23,1,1,1,0));
        tbl.push_back(v(0,0,0,0,0, 23,1,1,1,0));

        foreach (tbl[i]) begin
            set_en = tbl[i].se; btn_up = tbl[i].up; btn_dn = tbl[i].dn;
            tick_in = tbl[i].tk; mode_24 = tbl[i].m24;
            cyc();
            chk($sformatf("vec%0d", i), tbl[i].hour, tbl[i].tens, tbl[i].ones, tbl[i].pm, tbl[i].carry);
        end
        set_en = 0; btn_up = 0; btn_dn = 0; tick_in = 0; mode_24 = 0;

        tick_in = 1;
        repeat (6) cyc();
        tick_in = 0;
        chk_v("to_hour5", hour_bin, 5);

        set_en = 1; btn_up = 1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            exp = 5;
            foreach (steps[j]) if (steps[j] <= k) exp++;
            chk_v($sformatf("repeat_e%0d", k), hour_bin, exp);
            chk_v("repeat_nocarry", carry_out, 0);
        end
        btn_up = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk_v("released", hour_bin, 10);
        end

        btn_up = 1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk_v("up_before_dn", hour_bin, (k < 8) ? 11 : 12);
        end
        btn_dn = 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk_v("dn_conflict", hour_bin, 12);
        end
        btn_up = 0; btn_dn = 0;
        cyc();

        btn_up = 1;
        repeat (19) cyc();
        chk_v("pre_reset_hour", hour_bin, 17);
        #2 reset = 1;
        #1 chk("reset_mid_repeat", RH, 0, 0, 0, 0);
        repeat (2) cyc();
        reset = 0;
        cyc();
        chk("post_reset", RH, 0, 7, 0, 0);
        for (int k = 0; k < 14; k++) begin
            cyc();
            chk_v("held_thru_reset", hour_bin, RH);
        end
        btn_up = 0;
        cyc();
        btn_up = 1;
        cyc();
        chk_v("new_press", hour_bin, RH + 1);
        btn_up = 0; set_en = 0;

        reset = 1;
        repeat (2) cyc();
        reset = 0;
        model_reset();
        set_en = 1; up_t = 0; dn_t = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(199) == 0) set_en = ~set_en;
            if ($urandom_range(49) == 0) mode_24 = ~mode_24;
            if (up_t == 0) begin
                btn_up = ($urandom_range(2) == 0);
                up_t = $urandom_range(30, 1);
            end else up_t--;
            if (dn_t == 0) begin
                btn_dn = ($urandom_range(3) == 0);
                dn_t = $urandom_range(30, 1);
            end else dn_t--;
            tick_in = ($urandom_range(3) == 0);
            model_edge();
            cyc();
            chk($sformatf("rand%0d", i), m_hour, m_tens, m_ones, m_pm, m_carry);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
